// File: rtl/histo_cdf_builder.sv
// Frame histogram binning followed by an in-place cumulative scan that feeds the equalizer.
// Optional HISTO_SAT_EN: bin increments and scan sums saturate instead of wrapping.
module histo_cdf_builder #(
  parameter int DataWidth      = 8,
  parameter int NumberOfLevels = 256,
  parameter int HistoWidth     = $clog2(640*480),
  parameter int FrameSize      = 640*480
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 frame_start,
  input  logic                                 pix_valid,
  input  logic [DataWidth-1:0]                 pix_data,
  output logic                                 pix_ready,
  output logic [HistoWidth*NumberOfLevels-1:0] cumulative_histo_data,
  output logic [HistoWidth-1:0]                min_cumulative_histo,
  output logic                                 start_equalization,
  output logic                                 cdf_valid,
  output logic                                 busy
);

  localparam int CntWidth = $clog2(FrameSize+1);
  localparam logic [DataWidth-1:0] LastIdx = DataWidth'(NumberOfLevels-1);
  localparam logic [CntWidth-1:0]  LastCnt = CntWidth'(FrameSize-1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_ACCUM = 3'd2;
  localparam logic [2:0] S_SCAN  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [DataWidth-1:0]  idx_q, idx_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [HistoWidth-1:0] acc_q, acc_d;
  logic [HistoWidth-1:0] min_q, min_d;
  logic                  min_found_q, min_found_d;
  logic                  cdf_valid_q, cdf_valid_d;

  logic                  accept;
  logic [DataWidth-1:0]  rd_idx;
  logic [HistoWidth-1:0] rd_val;
  logic [HistoWidth-1:0] inc_val;
  logic [HistoWidth-1:0] acc_next;

`ifdef HISTO_SAT_EN
  function automatic logic [HistoWidth-1:0] add_w(input logic [HistoWidth-1:0] a,
                                                  input logic [HistoWidth-1:0] b);
    logic [HistoWidth:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[HistoWidth] ? {HistoWidth{1'b1}} : s[HistoWidth-1:0];
  endfunction
`else
  function automatic logic [HistoWidth-1:0] add_w(input logic [HistoWidth-1:0] a,
                                                  input logic [HistoWidth-1:0] b);
    return a + b;
  endfunction
`endif

  assign pix_ready          = (state_q == S_ACCUM);
  assign busy               = (state_q == S_CLEAR) || (state_q == S_ACCUM) || (state_q == S_SCAN);
  assign start_equalization = (state_q == S_DONE);
  assign cdf_valid          = cdf_valid_q;
  assign min_cumulative_histo = min_q;
  assign accept             = pix_valid && pix_ready;

  // One shared read port: the pixel's bin while accumulating, the scan index otherwise.
  assign rd_idx   = (state_q == S_SCAN) ? idx_q : pix_data;
  assign rd_val   = cumulative_histo_data[int'(rd_idx)*HistoWidth +: HistoWidth];
  assign inc_val  = add_w(rd_val, HistoWidth'(1));
  assign acc_next = add_w(acc_q, rd_val);

  for (genvar gi = 0; gi < NumberOfLevels; gi++) begin : gen_bin
    localparam logic [DataWidth-1:0] BinIdx = DataWidth'(gi);
    logic [HistoWidth-1:0] bin_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        bin_q <= '0;
      end else if (state_q == S_CLEAR && idx_q == BinIdx) begin
        bin_q <= '0;
      end else if (accept && pix_data == BinIdx) begin
        bin_q <= inc_val;
      end else if (state_q == S_SCAN && idx_q == BinIdx) begin
        bin_q <= acc_next;
      end
    end

    assign cumulative_histo_data[gi*HistoWidth +: HistoWidth] = bin_q;
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    min_d       = min_q;
    min_found_d = min_found_q;
    cdf_valid_d = cdf_valid_q;
    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          cdf_valid_d = 1'b0;
          idx_d       = '0;
          state_d     = S_CLEAR;
        end
      end
      S_CLEAR: begin
        cnt_d       = '0;
        min_d       = '0;
        min_found_d = 1'b0;
        idx_d       = idx_q + DataWidth'(1);
        if (idx_q == LastIdx) begin
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CntWidth'(1);
          if (cnt_q == LastCnt) begin
            idx_d   = '0;
            acc_d   = '0;
            state_d = S_SCAN;
          end
        end
      end
      S_SCAN: begin
        acc_d = acc_next;
        idx_d = idx_q + DataWidth'(1);
        // Minimum non-zero CDF value is the first non-zero running sum.
        if (!min_found_q && acc_next != '0) begin
          min_d       = acc_next;
          min_found_d = 1'b1;
        end
        if (idx_q == LastIdx) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        cdf_valid_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      min_q       <= '0;
      min_found_q <= 1'b0;
      cdf_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      min_q       <= min_d;
      min_found_q <= min_found_d;
      cdf_valid_q <= cdf_valid_d;
    end
  end

endmodule

// File: tb/tb_histo_cdf_builder.sv
// Scoreboard bench: a wide-bin and a 3-bit-bin instance share one pixel stream; a monitor
// checks each start_equalization pulse against a histogram/prefix-sum reference.
module tb_histo_cdf_builder;

  localparam int DW  = 8;
  localparam int NL  = 256;
  localparam int HWB = 19;
  localparam int HWS = 3;
  localparam int FS  = 16;

  logic clk = 1'b0;
  logic rst, frame_start, pix_valid;
  logic [DW-1:0] pix_data;

  logic              b_ready, b_start, b_valid, b_busy;
  logic [HWB*NL-1:0] b_cdf;
  logic [HWB-1:0]    b_min;
  logic              s_ready, s_start, s_valid, s_busy;
  logic [HWS*NL-1:0] s_cdf;
  logic [HWS-1:0]    s_min;

  histo_cdf_builder #(.DataWidth(DW), .NumberOfLevels(NL), .HistoWidth(HWB), .FrameSize(FS)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(b_ready), .cumulative_histo_data(b_cdf), .min_cumulative_histo(b_min),
    .start_equalization(b_start), .cdf_valid(b_valid), .busy(b_busy));

  histo_cdf_builder #(.DataWidth(DW), .NumberOfLevels(NL), .HistoWidth(HWS), .FrameSize(FS)) dut_small (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(s_ready), .cumulative_histo_data(s_cdf), .min_cumulative_histo(s_min),
    .start_equalization(s_start), .cdf_valid(s_valid), .busy(s_busy));

  always #5 clk = ~clk;

  typedef struct {
    logic [HWB*NL-1:0] cdf_b;
    logic [HWB-1:0]    min_b;
    logic [HWS*NL-1:0] cdf_s;
    logic [HWS-1:0]    min_s;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   frame_no = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic cmp_cdf_b(input string name, input logic [HWB*NL-1:0] act, input logic [HWB*NL-1:0] req);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < NL; i++)
      if (bad < 0 && act[i*HWB +: HWB] !== req[i*HWB +: HWB]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s entry=%0d actual=%0d required=%0d", name, bad, act[bad*HWB +: HWB], req[bad*HWB +: HWB]);
    end
  endtask

  task automatic cmp_cdf_s(input string name, input logic [HWS*NL-1:0] act, input logic [HWS*NL-1:0] req);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < NL; i++)
      if (bad < 0 && act[i*HWS +: HWS] !== req[i*HWS +: HWS]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s entry=%0d actual=%0d required=%0d", name, bad, act[bad*HWS +: HWS], req[bad*HWS +: HWS]);
    end
  endtask

  // Reference: count pixels per value, then running sum, both limited to w bits.
  function automatic void model(input int vals[$], input int w, output int cdf[NL], output int mn);
    int h[NL];
    int mx;
    int s;
    mx = (1 << w) - 1;
    s  = 0;
    mn = 0;
    for (int i = 0; i < NL; i++) h[i] = 0;
    foreach (vals[k]) begin
`ifdef HISTO_SAT_EN
      if (h[vals[k]] < mx) h[vals[k]]++;
`else
      h[vals[k]] = (h[vals[k]] + 1) & mx;
`endif
    end
    for (int i = 0; i < NL; i++) begin
`ifdef HISTO_SAT_EN
      s = (s + h[i] > mx) ? mx : s + h[i];
`else
      s = (s + h[i]) & mx;
`endif
      cdf[i] = s;
      if (mn == 0 && s != 0) mn = s;
    end
  endfunction

  function automatic exp_t build_exp(input int vals[$]);
    exp_t e;
    int cb[NL];
    int cs[NL];
    int mb, ms;
    model(vals, HWB, cb, mb);
    model(vals, HWS, cs, ms);
    for (int i = 0; i < NL; i++) begin
      e.cdf_b[i*HWB +: HWB] = HWB'(cb[i]);
      e.cdf_s[i*HWS +: HWS] = HWS'(cs[i]);
    end
    e.min_b = HWB'(mb);
    e.min_s = HWS'(ms);
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 64'(b_ready), 64'(0));
    check({tag, "_busy"}, 64'(b_busy), 64'(0));
    check({tag, "_valid"}, 64'(b_valid), 64'(0));
    check({tag, "_start"}, 64'(b_start), 64'(0));
    check({tag, "_min"}, 64'(b_min), 64'(0));
    check({tag, "_min_small"}, 64'(s_min), 64'(0));
    cmp_cdf_b({tag, "_cdf"}, b_cdf, '0);
    cmp_cdf_s({tag, "_cdf_small"}, s_cdf, '0);
    $display("reset-state check %s done", tag);
  endtask

  // Monitor: every start pulse must match the oldest queued expectation.
  initial begin
    bit follow;
    follow = 1'b0;
    forever begin
      @(negedge clk);
      if (follow) begin
        follow = 1'b0;
        check("post_start_valid", 64'(b_valid), 64'(1));
        check("post_start_valid_small", 64'(s_valid), 64'(1));
      end
      if (b_start) begin
        check("start_small_sync", 64'(s_start), 64'(1));
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start actual=1 required=0");
        end else begin
          mon_e = sb.pop_front();
          cmp_cdf_b("cdf", b_cdf, mon_e.cdf_b);
          check("min", 64'(b_min), 64'(mon_e.min_b));
          cmp_cdf_s("cdf_small", s_cdf, mon_e.cdf_s);
          check("min_small", 64'(s_min), 64'(mon_e.min_s));
          check("latency", 64'(cyc - last_acc), 64'(NL + 1));
          $display("frame %0d: start seen, min=%0d min_small=%0d latency=%0d",
                   frame_no, b_min, s_min, cyc - last_acc);
          follow = 1'b1;
        end
      end
    end
  end

  task automatic send_frame(input int vals[$], input bit rand_valid, input int fs_at, input int abort_at);
    int  i, t;
    bit  v, fs_done;
    frame_no++;
    if (abort_at < 0) begin
      last_exp = build_exp(vals);
      sb.push_back(last_exp);
    end
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("valid_cleared", 64'(b_valid), 64'(0));
    t = 0;
    while (!b_ready && t < NL + 20) begin
      @(negedge clk);
      t++;
    end
    if (!b_ready) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout actual=0 required=1");
      return;
    end
    i = 0;
    t = 0;
    fs_done = 1'b0;
    while (i < vals.size() && t < 2000) begin
      if (abort_at >= 0 && i == abort_at) break;
      v = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
      frame_start = (i == fs_at && !fs_done);
      if (i == fs_at) fs_done = 1'b1;
      pix_valid = v;
      pix_data  = v ? DW'(vals[i]) : DW'($urandom);
      if (v && b_ready) begin
        last_acc = cyc;
        i++;
      end
      @(negedge clk);
      t++;
    end
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    pix_data    = DW'($urandom);
    if (abort_at < 0 && i < vals.size()) begin
      checks++;
      failures++;
      $display("FAIL beat_timeout actual=%0d required=%0d", i, vals.size());
    end
    $display("frame %0d: %0d beats sent", frame_no, i);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < NL + 60) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout actual=%0d required=0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int vals[$];
    rst = 1'b1; frame_start = 1'b0; pix_valid = 1'b0; pix_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_reset_state("reset");

    vals = {};
    for (int k = 0; k < FS; k++) vals.push_back(5);
    send_frame(vals, 1'b0, -1, -1);
    wait_done();

    vals = {};
    for (int k = 0; k < FS; k++) vals.push_back(k);
    send_frame(vals, 1'b0, -1, -1);
    wait_done();
    repeat (20) @(negedge clk);
    check("valid_held", 64'(b_valid), 64'(1));
    check("busy_idle", 64'(b_busy), 64'(0));
    cmp_cdf_b("cdf_held", b_cdf, last_exp.cdf_b);

    vals = {};
    for (int k = 0; k < FS; k++) vals.push_back((k % 2 == 1) ? 200 : 3);
    send_frame(vals, 1'b1, 5, -1);
    wait_done();

    vals = {};
    for (int k = 0; k < FS; k++) vals.push_back($urandom_range(0, NL - 1));
    send_frame(vals, 1'b1, -1, 7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("abort");

    vals = {};
    for (int k = 0; k < FS; k++) vals.push_back(0);
    send_frame(vals, 1'b0, -1, -1);
    wait_done();

    for (int r = 0; r < 4; r++) begin
      vals = {};
      for (int k = 0; k < FS; k++) vals.push_back($urandom_range(0, (r < 2) ? NL - 1 : 3));
      send_frame(vals, r[0], -1, -1);
      wait_done();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/histo_cdf_builder.md
Name: histo_cdf_builder

Overview:
Producer side of the equalization path. Accepts one frame of pixels over a valid/ready stream and bins them into a NumberOfLevels-entry histogram. It then converts the histogram in place into a cumulative histogram (CDF) and finds the minimum non-zero CDF value. It drives the flattened CDF bus, the minimum CDF value and a one-cycle start pulse straight into the equalizer's cumulativeHistoData, minCumulativeHisto and startEquilization inputs.

Parameters:
DataWidth, 8, pixel width in bits.
NumberOfLevels, 256, number of histogram bins; equals 2**DataWidth.
HistoWidth, $clog2(640*480), width in bits of one bin or CDF entry.
FrameSize, 640*480, number of pixels per frame.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
frame_start  input  1  single-cycle pulse; arms the block for a new frame.
pix_valid  input  1  pixel beat valid.
pix_data  input  DataWidth  pixel value, used as the bin index.
pix_ready  output  1  block can accept a pixel.
cumulative_histo_data  output  HistoWidth*NumberOfLevels  flattened CDF; entry i is at [i*HistoWidth +: HistoWidth].
min_cumulative_histo  output  HistoWidth  first non-zero CDF entry.
start_equalization  output  1  one-cycle pulse when the CDF is complete.
cdf_valid  output  1  CDF outputs are stable and valid.
busy  output  1  high in CLEAR, ACCUM and SCAN.

Behaviour:
- Reset (synchronous, active-high; clock clk) forces:
  - state IDLE;
  - all bins, min_cumulative_histo and the pixel counter to 0;
  - pix_ready, start_equalization, cdf_valid and busy to 0.
- Storage is one bin array of NumberOfLevels x HistoWidth registers. cumulative_histo_data is this array flattened, with no extra copy.
- States:
  - IDLE: waits for frame_start. On frame_start: cdf_valid <= 0, go to CLEAR.
  - CLEAR: zeroes one bin per cycle for indices 0..NumberOfLevels-1, so it lasts NumberOfLevels cycles. Also zeroes the pixel counter and min_cumulative_histo, then goes to ACCUM.
  - ACCUM:
    - pix_ready = 1 (combinational on state).
    - A beat is accepted when pix_valid && pix_ready. Each accepted beat does bin[pix_data] += 1 and increments the counter.
    - pix_data is ignored when pix_valid = 0.
    - The beat that brings the counter to FrameSize is the last one; the next state is SCAN.
    - pix_ready deasserts the cycle after the last beat.
  - SCAN:
    - One bin per cycle, index i = 0..NumberOfLevels-1: acc_next = acc + bin[i]; bin[i] <= acc_next; acc <= acc_next. acc starts at 0.
    - The first i where acc_next != 0 latches min_cumulative_histo <= acc_next. It is latched once per frame.
    - Lasts NumberOfLevels cycles, then goes to DONE.
  - DONE: start_equalization = 1 for exactly one cycle, cdf_valid <= 1, go to IDLE.
- Latency: start_equalization is asserted NumberOfLevels+1 cycles after the cycle of the last accepted beat.
- busy = 1 in CLEAR, ACCUM and SCAN.
- cdf_valid stays 1 in IDLE until the next frame_start.
- frame_start outside IDLE is ignored.
- Pixels offered outside ACCUM are not accepted (pix_ready = 0).
- If the CDF never becomes non-zero (possible only on wrap), min_cumulative_histo stays 0.
- Arithmetic: bin increments and cumulative sums are HistoWidth-bit unsigned. Overflow handling is set by HISTO_SAT_EN.
- The pixel counter is $clog2(FrameSize+1) bits.
- rst asserted in any state aborts the operation and applies reset values on the next edge; no partial results persist.

Optional Feature:
HISTO_SAT_EN:
- Defined: bin increments and SCAN sums saturate at 2**HistoWidth-1.
- Undefined: both wrap modulo 2**HistoWidth.
- Neither setting changes the pixel count or the timing.

Test Plan:
1. Reset, then 10 idle cycles -> pix_ready = 0, busy = 0, cdf_valid = 0, start_equalization = 0, all CDF entries 0, min_cumulative_histo = 0.
2. FrameSize=16; frame_start, then 16 beats of value 5 with pix_valid held high -> cdf[0..4] = 0, cdf[5..255] = 16, min = 16, start_equalization pulses once, exactly 257 cycles after the last beat.
3. FrameSize=16; beats 0,1,...,15 -> cdf[k] = k+1 for k < 16, cdf[k] = 16 for k >= 16, min = 1, cdf_valid = 1 until the next frame_start.
4. FrameSize=16; pix_valid toggled pseudo-randomly, with junk pix_data while pix_valid = 0, 8 beats of value 3 and 8 of value 200 accepted -> cdf[3..199] = 8, cdf[200..255] = 16, min = 8. A frame_start pulsed during ACCUM is ignored.
5. rst pulsed mid-ACCUM after 7 beats, then a full frame of value 0 -> cdf[all] = 16, min = 16; no residue from the aborted frame.
6. HistoWidth=3, FrameSize=16, all beats value 0:
   - with HISTO_SAT_EN: cdf[all] = 7, min = 7;
   - without: cdf[all] = 0, min = 0, start_equalization still pulses.
